// File: rtl/branch_predictor_update_ctrl_if.sv
// Predictor-update bundle: retirement inputs, pattern-table port, fetch redirect and status.
// PRED_STATS_EN adds the stat_branches / stat_mispredicts counters to the bundle.
interface branch_predictor_update_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int IDX_W  = 6
);
  logic              exec_done;
  logic [21:0]       branch;
  logic [ADDR_W-1:0] branch_addr;
  logic [15:0]       W;
  logic              CY;
  logic [IDX_W-1:0]  tbl_addr;
  logic              tbl_rd_en;
  logic [1:0]        tbl_rd_data;
  logic              tbl_wr_en;
  logic [1:0]        tbl_wr_data;
  logic              flush;
  logic [ADDR_W-1:0] redirect_addr;
  logic              busy;
  logic              overflow;
`ifdef PRED_STATS_EN
  logic [15:0]       stat_branches;
  logic [15:0]       stat_mispredicts;

  modport master (
    input  exec_done, branch, branch_addr, W, CY, tbl_rd_data,
    output tbl_addr, tbl_rd_en, tbl_wr_en, tbl_wr_data, flush, redirect_addr,
           busy, overflow, stat_branches, stat_mispredicts
  );
  modport slave (
    output exec_done, branch, branch_addr, W, CY, tbl_rd_data,
    input  tbl_addr, tbl_rd_en, tbl_wr_en, tbl_wr_data, flush, redirect_addr,
           busy, overflow, stat_branches, stat_mispredicts
  );
`else
  modport master (
    input  exec_done, branch, branch_addr, W, CY, tbl_rd_data,
    output tbl_addr, tbl_rd_en, tbl_wr_en, tbl_wr_data, flush, redirect_addr,
           busy, overflow
  );
  modport slave (
    output exec_done, branch, branch_addr, W, CY, tbl_rd_data,
    input  tbl_addr, tbl_rd_en, tbl_wr_en, tbl_wr_data, flush, redirect_addr,
           busy, overflow
  );
`endif
endinterface

// File: rtl/branch_predictor_update_ctrl.sv
// Read-modify-write sequencer for the 2-bit branch pattern table with a one-entry pending buffer.
// Optional statistics counters are compiled in with PRED_STATS_EN.
module branch_predictor_update_ctrl #(
  parameter int ADDR_W = 11,
  parameter int IDX_W  = 6
) (
  input logic                            clock,
  input logic                            reset_n,
  branch_predictor_update_ctrl_if.master bp
);

  typedef enum logic [1:0] {IDLE, READ, RESOLVE, WRITE} state_e;

  typedef struct packed {
    logic [1:0]        cond;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       w;
    logic              cy;
  } br_t;

  state_e state_q, state_d;
  br_t    work_q, work_d;
  br_t    pend_q, pend_d;
  logic   pend_vld_q, pend_vld_d;
  logic   ovf_q, ovf_d;
  logic [1:0] new_ctr_q, new_ctr_d;
  logic   misp_q, misp_d;
  logic   taken_q, taken_d;

  logic       accept;
  br_t        incoming;
  logic [1:0] rd_ctr;
  logic       taken;
  logic [1:0] upd_ctr;
  logic       unused_bits;

  assign unused_bits = ^bp.branch[18:11];
  assign accept      = bp.exec_done & bp.branch[21];

  always_comb begin
    incoming.cond   = bp.branch[20:19];
    incoming.target = ADDR_W'(bp.branch[10:0]);
    incoming.addr   = bp.branch_addr;
    incoming.w      = bp.W;
    incoming.cy     = bp.CY;
  end

  // Outcome and counter update, meaningful only while RESOLVE holds the read data.
  always_comb begin
    rd_ctr = bp.tbl_rd_data;
    unique case (work_q.cond)
      2'b00:   taken = 1'b1;
      2'b01:   taken = work_q.cy;
      2'b10:   taken = (work_q.w == 16'h0000);
      default: taken = (work_q.w != 16'h0000);
    endcase
    if (taken) upd_ctr = (rd_ctr == 2'b11) ? rd_ctr : rd_ctr + 2'b01;
    else       upd_ctr = (rd_ctr == 2'b00) ? rd_ctr : rd_ctr - 2'b01;
  end

  // NOTE: every always_comb output is given its hold value first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ovf_d      = ovf_q;
    new_ctr_d  = new_ctr_q;
    misp_d     = misp_q;
    taken_d    = taken_q;
    unique case (state_q)
      IDLE, WRITE: begin
        if (pend_vld_q) begin
          // Chain the buffered branch; a same-cycle accept refills the slot.
          work_d     = pend_q;
          state_d    = READ;
          pend_vld_d = accept;
          if (accept) pend_d = incoming;
        end else if (accept && state_q == IDLE) begin
          work_d  = incoming;
          state_d = READ;
        end else begin
          state_d = IDLE;
          if (accept) begin
            pend_d     = incoming;
            pend_vld_d = 1'b1;
          end
        end
      end
      READ, RESOLVE: begin
        if (state_q == READ) begin
          state_d = RESOLVE;
        end else begin
          new_ctr_d = upd_ctr;
          misp_d    = rd_ctr[1] != taken;
          taken_d   = taken;
          state_d   = WRITE;
        end
        if (accept) begin
          if (!pend_vld_q) begin
            pend_d     = incoming;
            pend_vld_d = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: async reset with non-blocking updates; reset aborts any in-flight sequence.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      work_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      new_ctr_q  <= 2'b00;
      misp_q     <= 1'b0;
      taken_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ovf_q      <= ovf_d;
      new_ctr_q  <= new_ctr_d;
      misp_q     <= misp_d;
      taken_q    <= taken_d;
    end
  end

  // Strobes are decoded from state so they can never leak into other states.
  assign bp.tbl_rd_en     = (state_q == READ);
  assign bp.tbl_wr_en     = (state_q == WRITE);
  assign bp.tbl_addr      = (state_q == READ || state_q == WRITE) ? work_q.addr[IDX_W-1:0] : '0;
  assign bp.tbl_wr_data   = (state_q == WRITE) ? new_ctr_q : 2'b00;
  assign bp.flush         = (state_q == WRITE) & misp_q;
  assign bp.redirect_addr = (state_q != WRITE) ? '0 :
                            taken_q ? work_q.target : work_q.addr + ADDR_W'(1);
  assign bp.busy          = (state_q != IDLE) | pend_vld_q;
  assign bp.overflow      = ovf_q;

`ifdef PRED_STATS_EN
  logic [15:0] stat_br_q, stat_br_d;
  logic [15:0] stat_misp_q, stat_misp_d;

  always_comb begin
    stat_br_d   = stat_br_q;
    stat_misp_d = stat_misp_q;
    if (bp.tbl_wr_en && stat_br_q != 16'hFFFF)   stat_br_d   = stat_br_q + 16'd1;
    if (bp.flush     && stat_misp_q != 16'hFFFF) stat_misp_d = stat_misp_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_br_q   <= 16'h0000;
      stat_misp_q <= 16'h0000;
    end else begin
      stat_br_q   <= stat_br_d;
      stat_misp_q <= stat_misp_d;
    end
  end

  assign bp.stat_branches    = stat_br_q;
  assign bp.stat_mispredicts = stat_misp_q;
`endif

endmodule

// File: tb/tb_branch_predictor_update_ctrl.sv
// Directed bench for branch_predictor_update_ctrl with a behavioural 64-entry pattern table.
// Stimulus is applied 1ns after each rising edge; outputs are checked in the same window.
module tb_branch_predictor_update_ctrl;

  localparam int ADDR_W = 11;
  localparam int IDX_W  = 6;

  logic clock = 1'b0;
  logic reset_n;

  branch_predictor_update_ctrl_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bp ();

  branch_predictor_update_ctrl #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bp      (bp.master)
  );

  always #5 clock = ~clock;

  // Pattern table model: synchronous read (data next cycle), write lands at the edge.
  logic [1:0]       tbl_mem [64];
  logic [1:0]       rd_q;
  logic             pl_en;
  logic [IDX_W-1:0] pl_idx;
  logic [1:0]       pl_val;

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) tbl_mem[i] <= 2'b00;
      rd_q <= 2'b00;
    end else begin
      if (pl_en)        tbl_mem[pl_idx]      <= pl_val;
      if (bp.tbl_wr_en) tbl_mem[bp.tbl_addr] <= bp.tbl_wr_data;
      if (bp.tbl_rd_en) rd_q                 <= tbl_mem[bp.tbl_addr];
    end
  end
  assign bp.tbl_rd_data = rd_q;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [21:0] mk_br(input logic [1:0] cond, input logic [10:0] tgt);
    return {1'b1, cond, 8'h00, tgt};
  endfunction

  task automatic preload(input logic [IDX_W-1:0] idx, input logic [1:0] val);
    pl_idx = idx;
    pl_val = val;
    pl_en  = 1'b1;
    step();
    pl_en  = 1'b0;
  endtask

  task automatic drive(input logic [10:0] addr, input logic [1:0] cond, input logic [10:0] tgt,
                       input logic [15:0] w, input logic cy);
    bp.exec_done   = 1'b1;
    bp.branch      = mk_br(cond, tgt);
    bp.branch_addr = addr;
    bp.W           = w;
    bp.CY          = cy;
  endtask

  task automatic idle_inputs();
    bp.exec_done = 1'b0;
    bp.branch    = '0;
  endtask

  // One isolated branch: READ at +1, RESOLVE at +2, WRITE at +3, idle at +4.
  task automatic run_branch(input string tag, input logic [10:0] addr, input logic [1:0] cond,
                            input logic [10:0] tgt, input logic [15:0] w, input logic cy,
                            input logic [1:0] exp_ctr, input logic exp_flush,
                            input logic [10:0] exp_redir);
    drive(addr, cond, tgt, w, cy);
    step();
    idle_inputs();
    check({tag, ".rd_en"},    32'(bp.tbl_rd_en), 32'd1);
    check({tag, ".rd_addr"},  32'(bp.tbl_addr),  32'(addr[IDX_W-1:0]));
    check({tag, ".busy"},     32'(bp.busy),      32'd1);
    step();
    check({tag, ".resolve"},  32'({bp.tbl_rd_en, bp.tbl_wr_en, bp.flush}), 32'd0);
    step();
    check({tag, ".wr_en"},    32'(bp.tbl_wr_en),     32'd1);
    check({tag, ".wr_addr"},  32'(bp.tbl_addr),      32'(addr[IDX_W-1:0]));
    check({tag, ".wr_data"},  32'(bp.tbl_wr_data),   32'(exp_ctr));
    check({tag, ".flush"},    32'(bp.flush),         32'(exp_flush));
    if (exp_flush) check({tag, ".redirect"}, 32'(bp.redirect_addr), 32'(exp_redir));
    step();
    check({tag, ".after"},    32'({bp.tbl_wr_en, bp.flush, bp.busy}), 32'd0);
  endtask

  initial begin
    int n_wr;
    reset_n        = 1'b0;
    pl_en          = 1'b0;
    pl_idx         = '0;
    pl_val         = 2'b00;
    bp.exec_done   = 1'b0;
    bp.branch      = '0;
    bp.branch_addr = '0;
    bp.W           = '0;
    bp.CY          = 1'b0;
    repeat (3) step();
    check("rst.strobes",  32'({bp.tbl_rd_en, bp.tbl_wr_en, bp.flush}), 32'd0);
    check("rst.busy_ovf", 32'({bp.busy, bp.overflow}),                 32'd0);
    check("rst.addr",     32'(bp.tbl_addr),                            32'd0);
    check("rst.redirect", 32'(bp.redirect_addr),                       32'd0);
    reset_n = 1'b1;
    step();

    // Cold table, always-taken, predicted not-taken.
    run_branch("cold", 11'h010, 2'b00, 11'h200, 16'h0000, 1'b0, 2'd1, 1'b1, 11'h200);

    // exec_done without is_branch is ignored.
    bp.exec_done = 1'b1;
    bp.branch    = 22'h000200;
    step();
    idle_inputs();
    check("nonbr.busy",  32'(bp.busy),      32'd0);
    check("nonbr.rd_en", 32'(bp.tbl_rd_en), 32'd0);

    // Saturation and condition decode.
    preload(6'd1, 2'd3);
    run_branch("sat_hi",  11'h001, 2'b01, 11'h123, 16'h0000, 1'b1, 2'd3, 1'b0, 11'h000);
    preload(6'd2, 2'd0);
    run_branch("sat_lo",  11'h002, 2'b10, 11'h124, 16'h0001, 1'b0, 2'd0, 1'b0, 11'h000);
    preload(6'd3, 2'd2);
    run_branch("dec_nt",  11'h003, 2'b11, 11'h125, 16'h0000, 1'b0, 2'd1, 1'b1, 11'h004);
    preload(6'd63, 2'd3);
    run_branch("wrap",    11'h7FF, 2'b10, 11'h126, 16'h0005, 1'b0, 2'd2, 1'b1, 11'h000);
    preload(6'd4, 2'd2);
    run_branch("cy_zero", 11'h004, 2'b01, 11'h127, 16'h0000, 1'b0, 2'd1, 1'b1, 11'h005);

    // Back-to-back on the same index: the second read must see the first write (1->2->3).
    preload(6'd32, 2'd1);
    drive(11'h020, 2'b00, 11'h300, 16'h0000, 1'b0);
    check("b2b.c0_busy", 32'(bp.busy), 32'd0);
    step();
    drive(11'h020, 2'b00, 11'h300, 16'h0000, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("b2b.c%0d_busy", c),  32'(bp.busy),      32'((c <= 6) ? 1 : 0));
      check($sformatf("b2b.c%0d_wr_en", c), 32'(bp.tbl_wr_en), 32'((c == 3 || c == 6) ? 1 : 0));
      if (c == 3) begin
        check("b2b.w1_data",  32'(bp.tbl_wr_data),   32'd2);
        check("b2b.w1_flush", 32'(bp.flush),         32'd1);
        check("b2b.w1_redir", 32'(bp.redirect_addr), 32'h300);
      end
      if (c == 6) begin
        check("b2b.w2_data",  32'(bp.tbl_wr_data), 32'd3);
        check("b2b.w2_flush", 32'(bp.flush),       32'd0);
      end
      step();
      idle_inputs();
    end
    check("b2b.overflow", 32'(bp.overflow), 32'd0);

    // Three consecutive accepts: third is lost, overflow sticks.
    drive(11'h030, 2'b00, 11'h010, 16'h0000, 1'b0);
    step();
    drive(11'h031, 2'b00, 11'h011, 16'h0000, 1'b0);
    step();
    drive(11'h032, 2'b00, 11'h012, 16'h0000, 1'b0);
    check("ovf.before", 32'(bp.overflow), 32'd0);
    step();
    idle_inputs();
    check("ovf.set", 32'(bp.overflow), 32'd1);
    n_wr = 0;
    for (int c = 3; c <= 12; c++) begin
      if (bp.tbl_wr_en) n_wr++;
      step();
    end
    check("ovf.writes", 32'(n_wr),        32'd2);
    check("ovf.sticky", 32'(bp.overflow), 32'd1);
    check("ovf.idle",   32'(bp.busy),     32'd0);

    // Reset during RESOLVE aborts without writing.
    drive(11'h005, 2'b00, 11'h055, 16'h0000, 1'b0);
    step();
    idle_inputs();
    step();
    reset_n = 1'b0;
    #1;
    check("rmid.strobes",  32'({bp.tbl_rd_en, bp.tbl_wr_en, bp.flush}), 32'd0);
    check("rmid.busy_ovf", 32'({bp.busy, bp.overflow}),                 32'd0);
    check("rmid.outs",     32'({bp.tbl_addr, bp.tbl_wr_data, bp.redirect_addr}), 32'd0);
    n_wr = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (bp.tbl_wr_en) n_wr++;
    end
    check("rmid.no_write", 32'(n_wr), 32'd0);
    reset_n = 1'b1;
    step();
    run_branch("rmid.after", 11'h005, 2'b00, 11'h055, 16'h0000, 1'b0, 2'd1, 1'b1, 11'h055);

`ifdef PRED_STATS_EN
    reset_n = 1'b0;
    step();
    check("stat.rst", 32'({bp.stat_branches, bp.stat_mispredicts}), 32'd0);
    reset_n = 1'b1;
    step();
    preload(6'd9, 2'd3);
    run_branch("stat.b1", 11'h008, 2'b00, 11'h100, 16'h0000, 1'b0, 2'd1, 1'b1, 11'h100);
    run_branch("stat.b2", 11'h009, 2'b00, 11'h101, 16'h0000, 1'b0, 2'd3, 1'b0, 11'h000);
    run_branch("stat.b3", 11'h00A, 2'b00, 11'h102, 16'h0000, 1'b0, 2'd1, 1'b1, 11'h102);
    check("stat.branches",    32'(bp.stat_branches),    32'd3);
    check("stat.mispredicts", 32'(bp.stat_mispredicts), 32'd2);
    bp.exec_done = 1'b1;
    bp.branch    = 22'h000300;
    step();
    idle_inputs();
    repeat (4) step();
    check("stat.nonbr_br", 32'(bp.stat_branches),    32'd3);
    check("stat.nonbr_mp", 32'(bp.stat_mispredicts), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
